sipo_capture: RTL and testbench

SIPO_CAPTURE -- requirements
Module: sipo_capture

---
 rtl/sipo_capture_pkg.sv | 6 +
 rtl/sipo_shreg.sv | 20 ++
 rtl/sipo_capture.sv | 55 +++++
 tb/tb_sipo_capture.sv | 139 +++++++++++++
 4 files changed

// File: rtl/sipo_capture_pkg.sv
// sipo_capture_pkg: shared state encoding and bit-order constants
package sipo_capture_pkg;
    typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;
    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;
endpackage

// File: rtl/sipo_shreg.sv
// sipo_shreg: shift register with hold, insert-at-MSB/LSB and synchronous clear
module sipo_shreg
    import sipo_capture_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             insert,
    input  logic             dir,
    input  logic             bit_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] d
);
    always_comb d = (dir == DIR_MSB_FIRST) ? {q[WIDTH-2:0], bit_in} : {bit_in, q[WIDTH-1:1]};
    always_ff @(posedge clk)
        if (reset || clear) q <= '0;
        else if (insert) q <= d;
endmodule

// File: rtl/sipo_capture.sv
// sipo_capture: serial-to-parallel word capture with ready/valid output and overrun flag
module sipo_capture
    import sipo_capture_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             dir,
    input  logic             clear,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             out_valid,
    output logic             busy,
    output logic [CW-1:0]    bit_count,
    output logic             overrun
);
    state_t state, state_next;
    logic dir_l, eff_dir, take, last;
    logic [WIDTH-1:0] shreg, word_next;
    always_comb begin
        take    = bit_valid && !clear;
        eff_dir = (state == IDLE) ? dir : dir_l;
        last    = take && state == COLLECT && bit_count == CW'(WIDTH - 1);
    end
    sipo_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk(clk), .reset(reset), .clear(clear), .insert(take),
        .dir(eff_dir), .bit_in(bit_in), .q(shreg), .d(word_next)
    );
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_next;
    always_comb state_next = clear ? IDLE : !take ? state : last ? IDLE : COLLECT;
    always_comb busy = state == COLLECT;
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_count <= '0;
            dir_l     <= DIR_LSB_FIRST;
            out_word  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (clear) bit_count <= '0;
            else if (take) bit_count <= last ? '0 : bit_count + CW'(1);
            if (take && state == IDLE) dir_l <= dir;
            if (last && (!out_valid || out_ready)) begin
                out_word  <= word_next;
                out_valid <= 1'b1;
            end else if (out_ready) out_valid <= 1'b0;
            overrun <= !clear && (overrun || (last && out_valid && !out_ready));
        end
    end
endmodule

// File: tb/tb_sipo_capture.sv
// tb_sipo_capture: directed and randomized checks against a queue-based word model
module tb_sipo_capture;
    localparam int W = 8;
    logic clk = 0, reset = 0, bit_in = 0, bit_valid = 0, dir = 0, clear = 0, out_ready = 0;
    logic [W-1:0] out_word;
    logic out_valid, busy, overrun;
    logic [2:0] bit_count;
    int cmp = 0, bad = 0;
    bit chk_en = 0;
    bit q[$];
    bit m_dir = 0, m_valid = 0, m_ovr = 0;
    logic [W-1:0] m_word = '0;

    sipo_capture #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .dir(dir),
        .clear(clear), .out_ready(out_ready), .out_word(out_word), .out_valid(out_valid),
        .busy(busy), .bit_count(bit_count), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [W-1:0] w;
        bit done;
        if (reset) begin
            q.delete(); m_dir = 0; m_word = '0; m_valid = 0; m_ovr = 0;
        end else begin
            done = 0;
            w = '0;
            if (!clear && bit_valid) begin
                if (q.size() == 0) m_dir = dir;
                q.push_back(bit_in);
                if (q.size() == W) begin
                    for (int i = 0; i < W; i++) w[m_dir ? W - 1 - i : i] = q[i];
                    done = 1;
                    q.delete();
                end
            end
            if (clear) q.delete();
            if (done) begin
                if (!m_valid || out_ready) begin m_word = w; m_valid = 1; end
                else m_ovr = 1;
            end else if (out_ready) m_valid = 0;
            if (clear) m_ovr = 0;
        end
    endtask

    task automatic step(input logic bv, input logic b, input logic d, input logic clr,
                        input logic rdy, input logic rst);
        bit_valid = bv; bit_in = b; dir = d; clear = clr; out_ready = rdy; reset = rst;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send_word(input logic d, input logic [W-1:0] w, input logic rdy_last);
        for (int i = 0; i < W; i++)
            step(1, d ? w[W-1-i] : w[i], d, 0, (i == W - 1) ? rdy_last : 1'b0, 0);
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("cyc out_word", out_word, m_word);
        chk("cyc out_valid", out_valid, m_valid);
        chk("cyc overrun", overrun, m_ovr);
        chk("cyc busy", busy, q.size() != 0);
        chk("cyc bit_count", bit_count, q.size());
    end

    initial begin
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        chk_en = 1;
        chk("reset out_valid", out_valid, 0);
        chk("reset out_word", out_word, 0);
        chk("reset bit_count", bit_count, 0);
        chk("reset busy", busy, 0);
        step(0, 0, 0, 0, 0, 0);
        send_word(0, 8'hB3, 1);
        chk("lsb out_valid", out_valid, 1);
        chk("lsb out_word", out_word, 8'hB3);
        chk("lsb overrun", overrun, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("drain out_valid", out_valid, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0, 0, 0);
            chk("gap bit_count", bit_count, 3);
            chk("gap busy", busy, 1);
        end
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
        chk("msb out_word", out_word, 8'hF0);
        step(0, 0, 0, 0, 1, 0);
        send_word(0, 8'hB3, 0);
        send_word(0, 8'h5A, 0);
        chk("ovr overrun", overrun, 1);
        chk("ovr out_word", out_word, 8'hB3);
        step(0, 0, 0, 0, 1, 0);
        chk("ovr accept out_valid", out_valid, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("clear overrun", overrun, 0);
        send_word(0, 8'hB3, 0);
        send_word(0, 8'h5A, 1);
        chk("b2b out_word", out_word, 8'h5A);
        chk("b2b out_valid", out_valid, 1);
        chk("b2b overrun", overrun, 0);
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 1, 0, 0);
        chk("clr bit_count", bit_count, 0);
        chk("clr busy", busy, 0);
        step(1, 1, 0, 0, 0, 0);
        chk("clr restart bit_count", bit_count, 1);
        for (int i = 1; i < W; i++) step(1, i < 4, 0, 0, 0, 0);
        chk("clr out_word", out_word, 8'h0F);
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("rst out_word", out_word, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst bit_count", bit_count, 0);
        send_word(1, 8'hC3, 0);
        chk("rst new out_word", out_word, 8'hC3);
        for (int n = 0; n < 3000; n++)
            step($urandom_range(99) < 70, 1'($urandom), 1'($urandom), $urandom_range(99) < 3,
                 1'($urandom), $urandom_range(199) == 0);
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
